// File: rtl/vrf_pkg.sv
// Shared types and helpers for the masked vector register file.
//   vec_t        default-sized vector (16 lanes x 8 bits), lane 0 in the LSBs
//   vec_flat_t   wide flat carrier used by lane_merge so that any instance
//                size up to VEC_MAX_W bits can share one merge function
//   clr_state_e  bulk-clear FSM states
//   lane_merge   keeps old bits where the mask is 0 and takes new bits where it is 1
package vrf_pkg;

  localparam int LANES_DEF = 16;
  localparam int EW_DEF    = 8;

  // Upper bound on LANES*EW for any instance; synthesis trims the unused bits.
  localparam int VEC_MAX_W = 4096;

  typedef logic [LANES_DEF-1:0][EW_DEF-1:0] vec_t;
  typedef logic [VEC_MAX_W-1:0]             vec_flat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // mask_bits is the per-lane mask already expanded to one bit per data bit.
  function automatic vec_flat_t lane_merge(input vec_flat_t old_v,
                                           input vec_flat_t new_v,
                                           input vec_flat_t mask_bits);
    return (old_v & ~mask_bits) | (new_v & mask_bits);
  endfunction

endpackage

// File: rtl/vrf_read_port.sv
// One combinational read port of the vector register file.
//   ra     read address
//   regs   current register storage
//   we, wa, wd, wmask  write port of this cycle, used for same-cycle bypass
//   rd     read data: stored value, with masked write lanes bypassed in when
//          the write targets the same register; address 0 reads zero when
//          ZERO_R0 is set (no bypass there)
module vrf_read_port
  import vrf_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int EW      = 8,
  parameter int NREGS   = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic [AW-1:0]              ra,
  input  logic [LANES-1:0][EW-1:0]   regs [NREGS],
  input  logic                       we,
  input  logic [AW-1:0]              wa,
  input  logic [LANES-1:0][EW-1:0]   wd,
  input  logic [LANES-1:0]           wmask,
  output logic [LANES-1:0][EW-1:0]   rd
);

  localparam int VW = LANES * EW;

  logic [VW-1:0]            mask_bits;
  logic [LANES-1:0][EW-1:0] stored;
  logic [LANES-1:0][EW-1:0] merged;

  always_comb begin
    mask_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_bits[i*EW +: EW] = {EW{wmask[i]}};
    end
  end

  assign stored = regs[ra];
  assign merged = VW'(lane_merge(VEC_MAX_W'(stored), VEC_MAX_W'(wd),
                                 VEC_MAX_W'(mask_bits)));

  always_comb begin
    if (ZERO_R0 != 0 && ra == '0) begin
      rd = '0;
    end else if (we && wa == ra) begin
      rd = merged;
    end else begin
      rd = stored;
    end
  end

endmodule

// File: rtl/vec_reg_file_mask.sv
// Vector register file: NREGS registers of LANES x EW bits, flip-flop based.
// Per-lane masked writes, two bypassing read ports, optional hardwired-zero
// register 0, and a bulk-clear engine that zeroes one register per cycle.
//   clk, reset         clock and asynchronous active-low reset
//   we, wa, wd, wmask  masked write port
//   ra1/rd1, ra2/rd2   combinational read ports with same-cycle bypass
//   clr_req            pulse to start a bulk clear (ignored while clearing)
//   clr_busy           high for each cycle the clear engine is sweeping
//   clr_done           one-cycle pulse right after the sweep completes
//
// Clear FSM:
//   state | meaning
//   IDLE  | waiting for clr_req, index held at 0
//   CLEAR | zeroing reg[idx] this cycle, idx advances every cycle
//   DONE  | sweep finished, clr_done high for this single cycle
module vec_reg_file_mask
  import vrf_pkg::*;
#(
  parameter  int LANES   = 16,
  parameter  int EW      = 8,
  parameter  int NREGS   = 16,
  parameter  int ZERO_R0 = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [LANES-1:0][EW-1:0] wd,
  input  logic [LANES-1:0]         wmask,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic [LANES-1:0][EW-1:0] rd1,
  output logic [LANES-1:0][EW-1:0] rd2,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int VW = LANES * EW;

  typedef logic [LANES-1:0][EW-1:0] vec_w_t;

  vec_w_t     regs_q [NREGS];
  vec_w_t     regs_d [NREGS];
  clr_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [VW-1:0] mask_bits;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        // Wraps back to 0 after the last register since NREGS is a power of two.
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      CLEAR:   clr_busy = 1'b1;
      DONE:    clr_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- storage ----------------
  always_comb begin
    mask_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_bits[i*EW +: EW] = {EW{wmask[i]}};
    end
  end

  // The clear is applied first and the masked write merged on top, so a
  // write landing on the register being cleared keeps only its masked lanes.
  always_comb begin
    vec_w_t base;
    regs_d = regs_q;
    for (int r = 0; r < NREGS; r++) begin
      base = (state_q == CLEAR && idx_q == AW'(r)) ? '0 : regs_q[r];
      if (we && wa == AW'(r) && !(ZERO_R0 != 0 && r == 0)) begin
        regs_d[r] = VW'(lane_merge(VEC_MAX_W'(base), VEC_MAX_W'(wd),
                                   VEC_MAX_W'(mask_bits)));
      end else begin
        regs_d[r] = base;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  // ---------------- read ports ----------------
  vrf_read_port #(
    .LANES(LANES), .EW(EW), .NREGS(NREGS), .AW(AW), .ZERO_R0(ZERO_R0)
  ) u_rp1 (
    .ra(ra1), .regs(regs_q), .we(we), .wa(wa), .wd(wd), .wmask(wmask), .rd(rd1)
  );

  vrf_read_port #(
    .LANES(LANES), .EW(EW), .NREGS(NREGS), .AW(AW), .ZERO_R0(ZERO_R0)
  ) u_rp2 (
    .ra(ra2), .regs(regs_q), .we(we), .wa(wa), .wd(wd), .wmask(wmask), .rd(rd2)
  );

endmodule

// File: tb/tb_vec_reg_file_mask.sv
// Bench for vec_reg_file_mask: one instance with ZERO_R0=0 (dut_a) and one
// with ZERO_R0=1 (dut_b) share all inputs except reset. A behavioural model
// (register array plus a clear sweep position) predicts reads and handshakes.
module tb_vec_reg_file_mask;
  import vrf_pkg::*;

  localparam int NREGS = 16;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        we, clr_req;
  logic [3:0]  wa, ra1, ra2;
  vec_t        wd;
  logic [15:0] wmask;
  vec_t        rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_reg_file_mask #(.LANES(16), .EW(8), .NREGS(16), .ZERO_R0(0)) dut_a (
    .clk(clk), .reset(rst_a), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
  );

  vec_reg_file_mask #(.LANES(16), .EW(8), .NREGS(16), .ZERO_R0(1)) dut_b (
    .clk(clk), .reset(rst_b), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
  );

  // ---------------- reference model ----------------
  vec_t mem [2][NREGS];
  bit   clr_on [2];
  int   clr_pos [2];
  bit   done_flag [2];

  function automatic vec_t fill(input logic [7:0] b);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = b;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 8'($urandom) | 8'h01;
    return v;
  endfunction

  function automatic void model_reset(input int k);
    for (int r = 0; r < NREGS; r++) mem[k][r] = '0;
    clr_on[k]    = 1'b0;
    clr_pos[k]   = 0;
    done_flag[k] = 1'b0;
  endfunction

  // One rising edge with the inputs currently applied.
  function automatic void model_tick();
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 ? rst_a : rst_b) == 1'b0) continue;
      if (clr_on[k]) begin
        mem[k][clr_pos[k]] = '0;
        if (clr_pos[k] == NREGS - 1) begin
          clr_on[k]    = 1'b0;
          done_flag[k] = 1'b1;
        end else begin
          clr_pos[k] = clr_pos[k] + 1;
        end
      end else if (done_flag[k]) begin
        done_flag[k] = 1'b0;
      end else if (clr_req) begin
        clr_on[k]  = 1'b1;
        clr_pos[k] = 0;
      end
      if (we && !(k == 1 && wa == 4'd0)) begin
        for (int i = 0; i < 16; i++)
          if (wmask[i]) mem[k][wa][i] = wd[i];
      end
    end
  endfunction

  function automatic vec_t exp_rd(input int k, input logic [3:0] ra);
    vec_t v;
    if (k == 1 && ra == 4'd0) return '0;
    v = mem[k][ra];
    if (we && wa == ra)
      for (int i = 0; i < 16; i++) if (wmask[i]) v[i] = wd[i];
    return v;
  endfunction

  function automatic vec_t act_rd(input int k, input int p);
    if (k == 0) return (p == 1) ? rd1_a : rd2_a;
    return (p == 1) ? rd1_b : rd2_b;
  endfunction

  function automatic logic act_busy(input int k);
    return (k == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic act_done(input int k);
    return (k == 0) ? done_a : done_b;
  endfunction

  task automatic cyc();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; clr_req = 1'b0; wa = '0; wd = '0; wmask = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input vec_t d, input logic [15:0] m);
    we = 1'b1; wa = a; wd = d; wmask = m;
    cyc();
    we = 1'b0;
  endtask

  task automatic fill_all();
    for (int r = 0; r < NREGS; r++) do_write(4'(r), rand_vec(), 16'hFFFF);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    model_reset(0); model_reset(1);
    idle_inputs();
    ra1 = 4'd3; ra2 = 4'd15;
    cyc(); cyc();
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_rd(k, 1) !== '0) begin
        errors++; $display("FAIL reset_rd1[%0d] got %h exp 0", k, act_rd(k, 1));
      end
      checks++;
      if (act_rd(k, 2) !== '0) begin
        errors++; $display("FAIL reset_rd2[%0d] got %h exp 0", k, act_rd(k, 2));
      end
      checks++;
      if (act_busy(k) !== 1'b0 || act_done(k) !== 1'b0) begin
        errors++; $display("FAIL reset_hs[%0d] got busy=%b done=%b exp 0 0", k, act_busy(k), act_done(k));
      end
    end
  endtask

  task automatic test_masked_write();
    vec_t lit;
    do_write(4'd5, fill(8'hAA), 16'hFFFF);
    do_write(4'd5, fill(8'h55), 16'h00FF);
    ra1 = 4'd5;
    #1;
    for (int i = 0; i < 16; i++) lit[i] = (i < 8) ? 8'h55 : 8'hAA;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_rd(k, 1) !== lit) begin
        errors++; $display("FAIL masked_write[%0d] got %h exp %h", k, act_rd(k, 1), lit);
      end
    end
    // all-zero mask must leave the register untouched
    do_write(4'd5, fill(8'hEE), 16'h0000);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_rd(k, 1) !== lit) begin
        errors++; $display("FAIL zero_mask[%0d] got %h exp %h", k, act_rd(k, 1), lit);
      end
    end
  endtask

  task automatic test_bypass();
    vec_t lit;
    do_write(4'd7, fill(8'h11), 16'hFFFF);
    we = 1'b1; wa = 4'd7; wd = fill(8'h22); wmask = 16'h000F;
    ra1 = 4'd7; ra2 = 4'd7;
    #1;
    for (int i = 0; i < 16; i++) lit[i] = (i < 4) ? 8'h22 : 8'h11;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_rd(k, 1) !== lit || act_rd(k, 2) !== lit) begin
        errors++; $display("FAIL bypass[%0d] got %h / %h exp %h", k, act_rd(k, 1), act_rd(k, 2), lit);
      end
    end
    cyc();
    we = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_rd(k, 1) !== lit) begin
        errors++; $display("FAIL bypass_stored[%0d] got %h exp %h", k, act_rd(k, 1), lit);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      we    = 1'($urandom);
      wa    = 4'($urandom);
      for (int i = 0; i < 16; i++) wd[i] = 8'($urandom);
      wmask = 16'($urandom);
      ra1   = 4'($urandom);
      ra2   = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_rd(k, 1) !== exp_rd(k, ra1)) begin
          errors++; $display("FAIL rand_rd1[%0d] c=%0d ra=%0d got %h exp %h", k, c, ra1, act_rd(k, 1), exp_rd(k, ra1));
        end
        checks++;
        if (act_rd(k, 2) !== exp_rd(k, ra2)) begin
          errors++; $display("FAIL rand_rd2[%0d] c=%0d ra=%0d got %h exp %h", k, c, ra2, act_rd(k, 2), exp_rd(k, ra2));
        end
      end
      cyc();
    end
    we = 1'b0;
  endtask

  task automatic test_bulk_clear();
    int busy_cnt = 0, done_cnt = 0, last_busy = -1, done_at = -1;
    fill_all();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) clr_req = 1'b1;
      ra1 = 4'($urandom); ra2 = 4'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_busy(k) !== clr_on[k] || act_done(k) !== done_flag[k]) begin
          errors++; $display("FAIL clr_hs[%0d] c=%0d got busy=%b done=%b exp %b %b", k, c, act_busy(k), act_done(k), clr_on[k], done_flag[k]);
        end
        checks++;
        if (act_rd(k, 1) !== exp_rd(k, ra1)) begin
          errors++; $display("FAIL clr_rd[%0d] c=%0d got %h exp %h", k, c, act_rd(k, 1), exp_rd(k, ra1));
        end
      end
      if (busy_a) begin busy_cnt++; last_busy = c; end
      if (done_a) begin done_cnt++; done_at = c; end
      cyc();
      clr_req = 1'b0;
    end
    checks++;
    if (busy_cnt != 16) begin
      errors++; $display("FAIL clr_busy_len got %0d exp 16", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != last_busy + 1) begin
      errors++; $display("FAIL clr_done_pulse got count=%0d at=%0d exp count=1 at=%0d", done_cnt, done_at, last_busy + 1);
    end
    for (int r = 0; r < NREGS; r++) begin
      ra1 = 4'(r); ra2 = 4'(r);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_rd(k, 1) !== '0 || act_rd(k, 2) !== '0) begin
          errors++; $display("FAIL clr_zero[%0d] reg=%0d got %h exp 0", k, r, act_rd(k, 1));
        end
      end
    end
  endtask

  task automatic test_clear_collision();
    vec_t lit4;
    fill_all();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (clr_on[0] && clr_pos[0] == 4) begin
        we = 1'b1; wa = 4'd4; wd = fill(8'hFF); wmask = 16'h0003;
      end else if (clr_on[0] && clr_pos[0] == 6) begin
        we = 1'b1; wa = 4'd2; wd = fill(8'h3C); wmask = 16'hFFFF;
      end else begin
        we = 1'b0;
      end
      ra1 = 4'($urandom); ra2 = wa;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_rd(k, 1) !== exp_rd(k, ra1) || act_rd(k, 2) !== exp_rd(k, ra2)) begin
          errors++; $display("FAIL coll_rd[%0d] c=%0d got %h / %h exp %h / %h", k, c, act_rd(k, 1), act_rd(k, 2), exp_rd(k, ra1), exp_rd(k, ra2));
        end
      end
      cyc();
    end
    we = 1'b0;
    ra1 = 4'd4; ra2 = 4'd2;
    #1;
    for (int i = 0; i < 16; i++) lit4[i] = (i < 2) ? 8'hFF : 8'h00;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_rd(k, 1) !== lit4) begin
        errors++; $display("FAIL coll_reg4[%0d] got %h exp %h", k, act_rd(k, 1), lit4);
      end
      checks++;
      if (act_rd(k, 2) !== fill(8'h3C)) begin
        errors++; $display("FAIL coll_reg2[%0d] got %h exp %h", k, act_rd(k, 2), fill(8'h3C));
      end
    end
  endtask

  task automatic test_zero_r0_reset_mid_clear();
    bit reached = 1'b0;
    we = 1'b1; wa = 4'd0; wd = fill(8'h77); wmask = 16'hFFFF; ra1 = 4'd0; ra2 = 4'd0;
    #1;
    checks++;
    if (rd1_b !== '0 || rd1_a !== fill(8'h77)) begin
      errors++; $display("FAIL r0_bypass got b=%h a=%h exp b=0 a=%h", rd1_b, rd1_a, fill(8'h77));
    end
    cyc();
    we = 1'b0;
    #1;
    checks++;
    if (rd1_b !== '0 || rd1_a !== fill(8'h77)) begin
      errors++; $display("FAIL r0_stored got b=%h a=%h exp b=0 a=%h", rd1_b, rd1_a, fill(8'h77));
    end
    fill_all();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (clr_on[1] && clr_pos[1] == 6) begin reached = 1'b1; break; end
      cyc();
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL mid_clear_timeout got pos=%0d exp 6", clr_pos[1]);
    end
    #2;
    rst_b = 1'b0;
    model_reset(1);
    ra1 = 4'd3;
    #1;
    checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || rd1_b !== '0) begin
      errors++; $display("FAIL mid_reset_now got busy=%b done=%b rd=%h exp 0 0 0", busy_b, done_b, rd1_b);
    end
    cyc(); cyc();
    rst_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (busy_b !== 1'b0 || done_b !== 1'b0) begin
        errors++; $display("FAIL mid_reset_hs c=%0d got busy=%b done=%b exp 0 0", c, busy_b, done_b);
      end
      checks++;
      if (busy_a !== clr_on[0] || done_a !== done_flag[0]) begin
        errors++; $display("FAIL other_hs c=%0d got busy=%b done=%b exp %b %b", c, busy_a, done_a, clr_on[0], done_flag[0]);
      end
      cyc();
    end
    for (int r = 0; r < NREGS; r++) begin
      ra1 = 4'(r); ra2 = 4'(r);
      #1;
      checks++;
      if (rd1_b !== '0 || rd2_b !== '0) begin
        errors++; $display("FAIL mid_reset_zero reg=%0d got %h exp 0", r, rd1_b);
      end
      checks++;
      if (rd1_a !== exp_rd(0, ra1)) begin
        errors++; $display("FAIL other_regs reg=%0d got %h exp %h", r, rd1_a, exp_rd(0, ra1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_bypass();
    test_random(200);
    test_bulk_clear();
    test_clear_collision();
    test_random(50);
    test_zero_r0_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_reg_file_mask.md
Name: vec_reg_file_mask

Overview:
- Parametrised successor of the vector register file in the Decode stage: NREGS vector registers of LANES elements × EW bits each.
- Adds per-lane write masking, same-cycle write-to-read bypass, and a programmable register-zero hardwire.
- Adds a multi-cycle bulk-clear engine with a busy/done handshake, so software can zero the file between kernels without a reset.
- Feeds the vector ALU operand muxes. Written by the Writeback stage.

Parameters:
- LANES, 16, elements per vector register
- EW, 8, bits per element
- NREGS, 16, number of vector registers (power of two, ≥2)
- AW, $clog2(NREGS), register address width (derived, not overridden)
- ZERO_R0, 0, when 1 register 0 always reads zero and ignores writes

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  LANES×EW  write data, packed [LANES-1:0][EW-1:0]
- wmask  in  LANES  per-lane write enable; lane i written only if wmask[i]=1
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  LANES×EW  read data, port 1
- rd2  out  LANES×EW  read data, port 2
- clr_req  in  1  single-cycle pulse; starts a bulk clear
- clr_busy  out  1  high while a clear is in progress
- clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers go to 0; FSM goes to IDLE; clear index goes to 0.
  - clr_busy=0 and clr_done=0.
  - rd1 and rd2 therefore read all zeros.
- Write, on the rising edge when we=1:
  - reg[wa].lane[i] <= wd.lane[i] for every i with wmask[i]=1; other lanes hold their value.
  - we=1 with wmask=0 is a no-op.
- Read (combinational, zero latency):
  - rdN = reg[raN], except that bypass applies when we=1 and wa==raN.
  - Bypass value: lane i = wd.lane[i] if wmask[i]=1, else the stored lane.
  - Both ports bypass independently. ra1==ra2 is legal and returns identical data on both ports.
- ZERO_R0=1:
  - reads of address 0 return zero, with no bypass.
  - writes to address 0 are discarded.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: on clr_req=1 go to CLEAR, set idx=0, and raise clr_busy on the next cycle.
  - CLEAR: each cycle, reg[idx] <= 0 and idx <= idx+1. When idx==NREGS-1, go to DONE. This takes exactly NREGS cycles in CLEAR.
  - DONE: clr_busy=0, clr_done=1 for one cycle, then go to IDLE.
  - clr_req while in CLEAR or DONE is ignored; it is not queued.
  - clr_busy is high exactly for the cycles the FSM is in CLEAR.
- Simultaneous write and clear of the same register in one cycle:
  - the clear applies first, then the masked write merges on top.
  - Result: masked lanes = wd, unmasked lanes = 0.
- Writes to other registers during CLEAR proceed normally.
  - A register written before the clear index reaches it is zeroed later.
  - Consumers must wait for clr_done before relying on contents.
- Reads during CLEAR return the current storage (plus bypass). Registers the index has already passed read as zero.
- Reset asserted mid-clear: immediately return to IDLE with all registers zero; no clr_done pulse is produced.
- Storage uses flip-flops only (reset clearing required). No memory macro.

Decomposition:
- Shared package vrf_pkg holds:
  - typedef vec_t = logic [LANES-1:0][EW-1:0], with default LANES and EW;
  - the clear-FSM state enum clr_state_e {IDLE, CLEAR, DONE};
  - function lane_merge(old, new, mask) returning the masked merge, used by both the write path and the bypass path.
- One sub-module, vrf_read_port: one read port with its bypass logic and the ZERO_R0 check. It is instantiated twice.

Test Plan:
- Reset then read: reset low for 2 cycles, then release. ra1=3, ra2=15 → rd1 = rd2 = 0. clr_busy=0, clr_done=0.
- Masked write: we=1, wa=5, wd all lanes 8'hAA, wmask=16'hFFFF; next cycle wd all lanes 8'h55, wmask=16'h00FF. Then ra1=5 → lanes 0-7 read 8'h55, lanes 8-15 read 8'hAA.
- Bypass: reg 7 holds all 8'h11. In the same cycle drive we=1, wa=7, wd all 8'h22, wmask=16'h000F, ra1=ra2=7. Combinationally rd1 = rd2 = lanes 0-3 8'h22, rest 8'h11.
- Bulk clear: fill all 16 registers with nonzero data, then pulse clr_req.
  - clr_busy must be high for exactly 16 cycles.
  - clr_done must pulse 1 cycle after clr_busy falls.
  - Afterwards all registers read 0.
  - A second clr_req during busy must not extend busy.
- Write collision during clear: at the cycle idx==4, write wa=4, wd all 8'hFF, wmask=16'h0003 → after done, reg 4 lanes 0-1 = 8'hFF, rest 0. A write to reg 2 (already cleared) during CLEAR persists.
- ZERO_R0=1 build plus reset mid-clear: a write to reg 0 with all 8'h77 still reads 0. Assert reset at clear cycle 6 → clr_busy=0 immediately, no clr_done, all registers 0.
